dmem_io_bridge: RTL and testbench
=================================

// Module: dmem_io_bridge
// PURPOSE
//  Sits on the processor's data-memory port (address_dmem/data/wren/q_dmem), downstream of the M stage.
//  Decodes each word address to data RAM or to the Simon-game peripherals: LEDs, debounced buttons, countdown timer, LFSR.
//  The processor's MW latch captures the read data on its next rising edge.
// PARAMETERS
//  RAM_AW      12        RAM word-address width; RAM occupies 0x0000..(2^RAM_AW-1)
//  IO_BASE     32'h1000  base word address of the peripheral register block
//  N_BTN       4         number of buttons/LEDs
//  DB_CYCLES   250000    cycles a raw button must hold steady before the debounced level changes
//  TICK_DIV    50000     clock cycles per timer tick (1 ms at 50 MHz)
// PORTS
//  clock         in   1      master clock
//  reset         in   1      asynchronous, active-low (0 = reset)
//  address_dmem  in   32     word address from processor M stage
//  data          in   32     store data from processor
//  wren          in   1      store strobe, one cycle per sw
//  q_dmem        out  32     load data to processor
//  ram_addr      out  RAM_AW address to data RAM
//  ram_d         out  32     write data to RAM (= data)
//  ram_we        out  1      RAM write enable
//  ram_q         in   32     RAM read data, valid after the falling edge following ram_addr
//  btn_raw       in   N_BTN  asynchronous raw button inputs, 1 = pressed
//  leds          out  N_BTN  LED drive, 1 = lit
//  timer_irq     out  1      level; mirrors TIMER_STATUS.expired
// BEHAVIOUR
//  Decode: RAM hit if address_dmem[31:RAM_AW]==0; IO hit if address_dmem[31:3]==IO_BASE[31:3]; otherwise unmapped.
//  - ram_we = wren & RAM hit (combinational).
//  - Unmapped writes are ignored. Unmapped reads return 0.
//  Register map (offset from IO_BASE):
//   0 LED     RW  [N_BTN-1:0] drives leds
//   1 BTNSTAT R/W1C sticky press flags; set on debounced 0->1 edge
//   2 BTNLVL  RO  debounced levels
//   3 TLOAD   WO  a write loads count=data[15:0] and sets busy=1
//   4 TSTAT   R/W1C bit0 busy (RO), bit1 expired (W1C)
//   5 RNG     RO  16-bit LFSR, x^16+x^14+x^13+x^11+1; steps every clock; zero-extended on read
//   6,7       reserved: read 0, writes ignored
//  Read timing:
//  - Registered on the falling edge of clock.
//  - Source select and IO read value are sampled at negedge; q_dmem = sel_ram ? ram_q : io_rdata_q.
//  - Load data is therefore valid by the next rising edge, matching the RAM.
//  - Reading BTNSTAT/TSTAT has no side effect.
//  Write timing: IO registers update on the rising edge where wren=1.
//  Button path:
//  - 2-flop synchroniser, then per-button counter.
//  - Counter resets whenever the synced input equals the current level.
//  - Level flips when the counter reaches DB_CYCLES-1.
//  - A 0->1 level change sets that BTNSTAT bit the same cycle.
//  - If a set and a W1C of the same bit occur in one cycle, set wins.
//  Timer FSM (IDLE, RUN):
//  - Prescaler counts 0..TICK_DIV-1 only in RUN.
//  - At each wrap: count-=1; when count goes 1->0, go to IDLE, busy=0, expired=1.
//  - TLOAD with data[15:0]=0: go to IDLE and set expired=1 next cycle.
//  - TLOAD while in RUN: restart with the new count and clear the prescaler; expired is not cleared.
//  - Set of expired and W1C in the same cycle: set wins.
//  Reset (async, reset=0):
//  - leds=0, BTNSTAT=0, levels=0, debounce counters=0, synchronisers=0.
//  - Timer IDLE, count=0, prescaler=0, expired=0, timer_irq=0.
//  - LFSR=16'hACE1; q_dmem=0 (select=IO, io_rdata_q=0).
//  - Mid-operation reset aborts the timer and discards pending flags; the LFSR never reaches 0.
//  Widths: count is 16 bits, prescaler is $clog2(TICK_DIV) bits, debounce counter is $clog2(DB_CYCLES) bits.
//  Store data above each register's width is ignored.
// STRUCTURE
//  Shared package dmem_io_pkg: register offsets (OFF_LED..OFF_RNG), timer state enum {IDLE,RUN}, LFSR seed/taps.
//  Sub-module button_debouncer (one instance per button): sync + counter + level + rise pulse; parameter DB_CYCLES.
//  Timer, LFSR, decode and read mux stay in this module.
// TESTING (bench sets DB_CYCLES=4, TICK_DIV=3)
//  1. sw 0xDEADBEEF to 0x0010, lw 0x0010 -> q_dmem=0xDEADBEEF at next rising edge; ram_we pulses 1 cycle only.
//  2. sw 0x5 to IO_BASE+0 -> leds=4'b0101. lw IO_BASE+0 -> 5. lw 0x2000 -> 0, and ram_we stays 0 on sw 0x2000.
//  3. btn_raw[2] glitches high for 2 cycles -> BTNLVL stays 0. Held high for 8 cycles -> BTNLVL=4, BTNSTAT=4. sw 4 to IO_BASE+1 -> BTNSTAT=0.
//  4. sw 2 to IO_BASE+3 -> TSTAT=1 for 6 cycles, then TSTAT=2 and timer_irq=1. sw 2 to IO_BASE+4 -> timer_irq=0. TLOAD 0 -> TSTAT=2 next cycle.
//  5. After reset, lw IO_BASE+5 on two successive cycles -> nonzero, distinct values matching the golden LFSR from 16'hACE1.
//  6. Assert reset=0 mid-count with leds=0xF and BTNSTAT set -> all outputs 0 immediately, without waiting for a clock edge; timer IDLE after release.

Source files
------------

// File: rtl/dmem_io_pkg.sv
// Shared definitions for the data-memory / peripheral bridge: register
// offsets inside the peripheral block, timer states and the LFSR recipe.
package dmem_io_pkg;

  // Word offsets from IO_BASE; offsets 6 and 7 are reserved.
  localparam logic [2:0] OFF_LED     = 3'd0;
  localparam logic [2:0] OFF_BTNSTAT = 3'd1;
  localparam logic [2:0] OFF_BTNLVL  = 3'd2;
  localparam logic [2:0] OFF_TLOAD   = 3'd3;
  localparam logic [2:0] OFF_TSTAT   = 3'd4;
  localparam logic [2:0] OFF_RNG     = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_e;

  // x^16+x^14+x^13+x^11+1, shifting left: feedback from bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dmem_io_bridge_button_debouncer.sv
// One button: two-flop synchroniser, hold counter and debounced level.
// rise_o is high in the cycle whose rising edge moves the level 0->1.
module button_debouncer #(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flip;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count how long the synced input has disagreed with the level; flip when held long enough.
  always_comb begin
    flip    = 1'b0;
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      level_d = ~level_q;
      flip    = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Hold counter and debounced level registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
  // A flip while the synced input is high can only be a 0->1 change.
  assign rise_o  = flip & sync2_q;

endmodule

// File: rtl/dmem_io_bridge.sv
// Data-memory port bridge: splits processor loads/stores between the data
// RAM and the Simon-game peripheral block (LEDs, buttons, timer, LFSR).
// Load data is registered on the falling edge so it is stable for the
// processor's MW latch at the following rising edge, like the RAM.
module dmem_io_bridge
  import dmem_io_pkg::*;
#(
  parameter int          RAM_AW    = 12,
  parameter logic [31:0] IO_BASE   = 32'h1000,
  parameter int          N_BTN     = 4,
  parameter int          DB_CYCLES = 250000,
  parameter int          TICK_DIV  = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       address_dmem,
  input  logic [31:0]       data,
  input  logic              wren,
  output logic [31:0]       q_dmem,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_d,
  output logic              ram_we,
  input  logic [31:0]       ram_q,
  input  logic [N_BTN-1:0]  btn_raw,
  output logic [N_BTN-1:0]  leds,
  output logic              timer_irq
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  // Address decode.
  logic       ram_hit, io_hit;
  logic [2:0] io_off;
  logic       wr_io, wr_led, wr_btnstat, wr_tload, wr_tstat;

  assign ram_hit    = (address_dmem[31:RAM_AW] == '0);
  assign io_hit     = (address_dmem[31:3] == IO_BASE[31:3]);
  assign io_off     = address_dmem[2:0];
  assign wr_io      = wren & io_hit;
  assign wr_led     = wr_io && (io_off == OFF_LED);
  assign wr_btnstat = wr_io && (io_off == OFF_BTNSTAT);
  assign wr_tload   = wr_io && (io_off == OFF_TLOAD);
  assign wr_tstat   = wr_io && (io_off == OFF_TSTAT);

  assign ram_addr = address_dmem[RAM_AW-1:0];
  assign ram_d    = data;
  assign ram_we   = wren & ram_hit;

  // LED register.
  logic [N_BTN-1:0] leds_q;

  // Store to LED takes only the low N_BTN bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      leds_q <= '0;
    end else if (wr_led) begin
      leds_q <= data[N_BTN-1:0];
    end
  end

  assign leds = leds_q;

  // Buttons.
  logic [N_BTN-1:0] btn_lvl, btn_rise;
  logic [N_BTN-1:0] btnstat_q, btnstat_d, btn_clr;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    button_debouncer #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk_i  (clock),
      .rst_ni (reset),
      .raw_i  (btn_raw[i]),
      .level_o(btn_lvl[i]),
      .rise_o (btn_rise[i])
    );
  end

  // Sticky press flags: write-one-to-clear, a new press in the same cycle wins.
  always_comb begin
    btn_clr   = wr_btnstat ? data[N_BTN-1:0] : '0;
    btnstat_d = (btnstat_q & ~btn_clr) | btn_rise;
  end

  // Press flag register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btnstat_q <= '0;
    end else begin
      btnstat_q <= btnstat_d;
    end
  end

  // Countdown timer.
  timer_state_e  state_q;
  logic [15:0]   count_q;
  logic [PW-1:0] presc_q;
  logic          busy_q, expired_q;
  logic          tick, expired_set, expired_clr;

  assign tick        = (state_q == RUN) && (presc_q == PRESC_MAX);
  assign expired_set = wr_tload ? (data[15:0] == 16'd0) : (tick && (count_q == 16'd1));
  assign expired_clr = wr_tstat & data[1];

  // Timer FSM: a TLOAD always (re)starts from a clean prescaler; reaching zero parks in IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      if (wr_tload) begin
        presc_q <= '0;
        if (data[15:0] == 16'd0) begin
          state_q <= IDLE;
          count_q <= '0;
          busy_q  <= 1'b0;
        end else begin
          state_q <= RUN;
          count_q <= data[15:0];
          busy_q  <= 1'b1;
        end
      end else if (state_q == RUN) begin
        if (tick) begin
          presc_q <= '0;
          count_q <= count_q - 16'd1;
          if (count_q == 16'd1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end
      expired_q <= expired_set | (expired_q & ~expired_clr);
    end
  end

  assign timer_irq = expired_q;

  // Free-running random source.
  logic [15:0] lfsr_q;

  // Steps every clock; a nonzero seed keeps it off the all-zero lockup state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  // Read path.
  logic [31:0] io_rdata_d, io_rdata_q;
  logic        sel_ram_q;

  // Peripheral read value; unmapped and reserved addresses read as zero.
  always_comb begin
    io_rdata_d = '0;
    if (io_hit) begin
      case (io_off)
        OFF_LED:     io_rdata_d[N_BTN-1:0] = leds_q;
        OFF_BTNSTAT: io_rdata_d[N_BTN-1:0] = btnstat_q;
        OFF_BTNLVL:  io_rdata_d[N_BTN-1:0] = btn_lvl;
        OFF_TSTAT:   io_rdata_d[1:0]       = {expired_q, busy_q};
        OFF_RNG:     io_rdata_d[15:0]      = lfsr_q;
        default:     io_rdata_d            = '0;
      endcase
    end
  end

  // Capture source select and peripheral data on the falling edge, alongside the RAM read.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      sel_ram_q  <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      sel_ram_q  <= ram_hit;
      io_rdata_q <= io_rdata_d;
    end
  end

  assign q_dmem = sel_ram_q ? ram_q : io_rdata_q;

endmodule

// File: tb/tb_dmem_io_bridge.sv
// Bench for dmem_io_bridge with short debounce and timer constants.
// Loads push their expected value when issued; a monitor pops and compares
// once the falling-edge read register has captured the result.
module tb_dmem_io_bridge;

  localparam logic [31:0] IO = 32'h1000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [31:0] q_dmem;
  logic [11:0] ram_addr;
  logic [31:0] ram_d;
  logic        ram_we;
  logic [31:0] ram_q = '0;
  logic [3:0]  btn_raw = '0;
  logic [3:0]  leds;
  logic        timer_irq;

  dmem_io_bridge #(
    .RAM_AW   (12),
    .IO_BASE  (32'h1000),
    .N_BTN    (4),
    .DB_CYCLES(4),
    .TICK_DIV (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .address_dmem(address_dmem),
    .data        (data),
    .wren        (wren),
    .q_dmem      (q_dmem),
    .ram_addr    (ram_addr),
    .ram_d       (ram_d),
    .ram_we      (ram_we),
    .ram_q       (ram_q),
    .btn_raw     (btn_raw),
    .leds        (leds),
    .timer_irq   (timer_irq)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        rd_v = 1'b0;

  // Behavioural data RAM: write on rising edge, read data on falling edge.
  logic [31:0] mem [0:4095];
  initial for (int i = 0; i < 4096; i++) mem[i] = '0;
  always @(posedge clock) if (ram_we) mem[ram_addr] <= ram_d;
  always @(negedge clock) ram_q <= mem[ram_addr];

  // Reference LFSR.
  logic [15:0] m_lfsr;
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
  always @(posedge clock or negedge reset)
    if (!reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_step(m_lfsr);

  task automatic chk(input string t, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%08h want 0x%08h", t, act, exp);
    end
  endtask

  // Scoreboard monitor: a load issued this cycle is compared after the falling edge.
  always @(negedge clock) begin
    if (rd_v) begin
      #2;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, q_dmem, e);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    rd_v = 1'b0;
    wren = 1'b0;
    repeat (n) step();
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d, input logic we_exp, input string t);
    address_dmem = a;
    data         = d;
    wren         = 1'b1;
    rd_v         = 1'b0;
    #1;
    chk(t, {31'd0, ram_we}, {31'd0, we_exp});
    step();
    wren = 1'b0;
  endtask

  task automatic lw(input logic [31:0] a, input logic [31:0] e, input string t);
    address_dmem = a;
    wren         = 1'b0;
    rd_v         = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(t);
    step();
    rd_v = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_leds", {28'd0, leds}, 32'd0);
    chk("rst_irq", {31'd0, timer_irq}, 32'd0);
    chk("rst_q", q_dmem, 32'd0);
    reset = 1'b1;

    // LFSR straight out of reset
    lw(IO + 5, {16'd0, m_lfsr}, "rng0");
    lw(IO + 5, {16'd0, m_lfsr}, "rng1");
    chk("rng_first_golden", 32'h59C3, {16'd0, lfsr_step(16'hACE1)});

    // RAM store/load
    sw(32'h0010, 32'hDEADBEEF, 1'b1, "ram_we_hi");
    #1;
    chk("ram_we_lo", {31'd0, ram_we}, 32'd0);
    lw(32'h0010, 32'hDEADBEEF, "ram_rd");

    // LEDs, unmapped, reserved
    sw(IO + 0, 32'h5, 1'b0, "led_we0");
    chk("leds5", {28'd0, leds}, 32'h5);
    lw(IO + 0, 32'h5, "led_rd");
    lw(32'h2000, 32'h0, "unmapped_rd");
    sw(32'h2000, 32'h1234, 1'b0, "unmapped_we");
    sw(IO + 0, 32'hFFFF_FFFA, 1'b0, "led_wide_we");
    chk("leds_wide", {28'd0, leds}, 32'hA);
    lw(IO + 6, 32'h0, "reserved_rd");

    // Button glitch then real press
    btn_raw[2] = 1'b1;
    step(); step();
    btn_raw[2] = 1'b0;
    idle(6);
    lw(IO + 2, 32'h0, "btn_glitch_lvl");
    lw(IO + 1, 32'h0, "btn_glitch_stat");
    btn_raw[2] = 1'b1;
    idle(8);
    lw(IO + 2, 32'h4, "btn_lvl");
    lw(IO + 1, 32'h4, "btn_stat");
    sw(IO + 1, 32'h4, 1'b0, "btn_w1c_we");
    lw(IO + 1, 32'h0, "btn_stat_clr");
    btn_raw[2] = 1'b0;
    idle(8);
    lw(IO + 2, 32'h0, "btn_lvl_rel");
    lw(IO + 1, 32'h0, "btn_stat_rel");

    // Timer countdown of 2 ticks
    sw(IO + 3, 32'h2, 1'b0, "tload_we");
    for (int i = 0; i < 6; i++) lw(IO + 4, 32'h1, "tstat_busy");
    lw(IO + 4, 32'h2, "tstat_exp");
    chk("irq_hi", {31'd0, timer_irq}, 32'd1);
    sw(IO + 4, 32'h2, 1'b0, "tstat_w1c_we");
    chk("irq_clr", {31'd0, timer_irq}, 32'd0);
    sw(IO + 3, 32'h0, 1'b0, "tload0_we");
    lw(IO + 4, 32'h2, "tload0_exp");
    // Restart while running clears the prescaler
    sw(IO + 4, 32'h2, 1'b0, "tstat_w1c2_we");
    sw(IO + 3, 32'h5, 1'b0, "tload5_we");
    idle(1);
    sw(IO + 3, 32'h1, 1'b0, "tload1_we");
    for (int i = 0; i < 3; i++) lw(IO + 4, 32'h1, "restart_busy");
    lw(IO + 4, 32'h2, "restart_exp");

    // Mid-operation asynchronous reset
    sw(IO + 0, 32'hF, 1'b0, "led_f_we");
    btn_raw = 4'b0001;
    idle(8);
    sw(IO + 3, 32'h0, 1'b0, "tload0b_we");
    sw(IO + 3, 32'd100, 1'b0, "tload100_we");
    chk("irq_kept", {31'd0, timer_irq}, 32'd1);
    lw(IO + 1, 32'h1, "pre_rst_stat");
    lw(IO + 0, 32'hF, "pre_rst_led");
    #2;
    chk("pre_rst_q", q_dmem, 32'hF);
    reset = 1'b0;
    #1;
    chk("arst_leds", {28'd0, leds}, 32'd0);
    chk("arst_irq", {31'd0, timer_irq}, 32'd0);
    chk("arst_q", q_dmem, 32'd0);
    btn_raw = '0;
    idle(2);
    reset = 1'b1;
    lw(IO + 4, 32'h0, "post_rst_tstat");
    lw(IO + 1, 32'h0, "post_rst_stat");
    lw(IO + 2, 32'h0, "post_rst_lvl");
    lw(IO + 0, 32'h0, "post_rst_led");
    lw(IO + 5, {16'd0, m_lfsr}, "post_rst_rng");
    idle(4);
    lw(IO + 4, 32'h0, "post_rst_idle");

    idle(2);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
